// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory between the instruction-fetch port and the LW/SW data port.
// Build macro MEM_ARB_ROUND_ROBIN_EN replaces the fixed data-first tie-break with round robin.
module mem_arbiter #(
    parameter int MEM_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       owner_d;
    logic       lat_wr;
    logic       any_req;
    logic       grant_d;
    logic       capture;

    assign any_req  = if_req | d_req;
    assign capture  = (state == ISSUE && MEM_LAT == 1) || (state == WAIT && cnt == 4'd1);
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;  // 1 when the data port won the most recent grant

    assign grant_d = d_req & (~if_req | ~last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE && any_req) begin
            last_d <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            owner_d     <= 1'b0;
            lat_wr      <= 1'b0;
            if_rdata    <= 16'd0;
            if_valid    <= 1'b0;
            d_rdata     <= 16'd0;
            d_valid     <= 1'b0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= 16'd0;
            mem_data_in <= 16'd0;
        end else begin
            // NOTE: valid pulses default low every cycle; the capture assignment further down overrides it.
            if_valid <= 1'b0;
            d_valid  <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d    <= grant_d;
                        lat_wr     <= grant_d & d_wr;
                        mem_enable <= 1'b1;
                        mem_wr     <= grant_d & d_wr;
                        mem_addr   <= grant_d ? d_addr : if_addr;
                        if (grant_d) begin
                            mem_data_in <= d_wdata;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_enable <= 1'b0;
                    mem_wr     <= 1'b0;
                    cnt        <= LAT_LOAD;
                    state      <= (MEM_LAT == 1) ? DONE : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Read data lands in the owner's register so the valid pulse and data appear together in DONE.
            if (capture) begin
                if (owner_d) begin
                    d_rdata <= lat_wr ? 16'd0 : mem_data_out;
                    d_valid <= 1'b1;
                end else begin
                    if_rdata <= mem_data_out;
                    if_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: MEM_LAT=4 main instance with a memory model, plus a MEM_LAT=1 instance.
module tb_mem_arbiter;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        if_req, d_req, d_wr;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_data_in, mem_data_out;
    logic        if_valid, if_stall, d_valid, d_stall, mem_enable, mem_wr;

    logic        if_req1, d_req1, d_wr1;
    logic [15:0] if_addr1, d_addr1, d_wdata1;
    logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_data_in1, mem_data_out1;
    logic        if_valid1, if_stall1, d_valid1, d_stall1, mem_enable1, mem_wr1;

    int checks = 0;
    int errors = 0;

    logic [15:0] if_q[$];
    logic [15:0] d_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    mem_arbiter #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_valid(if_valid1), .if_stall(if_stall1),
        .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .d_rdata(d_rdata1), .d_valid(d_valid1), .d_stall(d_stall1),
        .mem_enable(mem_enable1), .mem_wr(mem_wr1), .mem_addr(mem_addr1),
        .mem_data_in(mem_data_in1), .mem_data_out(mem_data_out1)
    );

    // Memory model: fixed pattern, one special word, and the most recent store.
    logic        wr_seen = 1'b0;
    logic [15:0] wr_addr_q = 16'd0;
    logic [15:0] wr_data_q = 16'd0;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        if (wr_seen && a == wr_addr_q) return wr_data_q;
        if (a == 16'h0010) return 16'hA123;
        return a ^ 16'h5A5A;
    endfunction

    always_comb mem_data_out  = mem_model(mem_addr);
    always_comb mem_data_out1 = mem_addr1 ^ 16'h5A5A;

    always @(posedge clk) begin
        if (mem_enable && mem_wr) begin
            wr_seen   <= 1'b1;
            wr_addr_q <= mem_addr;
            wr_data_q <= mem_data_in;
        end
    end

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (if_valid && d_valid) begin
                errors++;
                $display("FAIL both_valid: if_valid=%b d_valid=%b, required not both high", if_valid, d_valid);
            end
            if (if_valid) begin
                checks++;
                if (if_q.size() == 0) begin
                    errors++;
                    $display("FAIL if_unexpected: if_valid with if_rdata=%h, no fetch outstanding", if_rdata);
                end else begin
                    logic [15:0] exp_if;
                    exp_if = if_q.pop_front();
                    if (if_rdata !== exp_if) begin
                        errors++;
                        $display("FAIL if_rdata: got %h, required %h", if_rdata, exp_if);
                    end
                end
            end
            if (d_valid) begin
                checks++;
                if (d_q.size() == 0) begin
                    errors++;
                    $display("FAIL d_unexpected: d_valid with d_rdata=%h, no data access outstanding", d_rdata);
                end else begin
                    logic [15:0] exp_d;
                    exp_d = d_q.pop_front();
                    if (d_rdata !== exp_d) begin
                        errors++;
                        $display("FAIL d_rdata: got %h, required %h", d_rdata, exp_d);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if_q.delete();
        d_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_enable, mem_wr, if_valid, d_valid, if_stall, d_stall} !== 6'b0 ||
            mem_addr !== 16'd0 || mem_data_in !== 16'd0 || if_rdata !== 16'd0 || d_rdata !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: en=%b wr=%b ifv=%b dv=%b addr=%h din=%h ifr=%h dr=%h, required all 0",
                     mem_enable, mem_wr, if_valid, d_valid, mem_addr, mem_data_in, if_rdata, d_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        int pulses;
        if_req  = 1'b1;
        if_addr = 16'h0040;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_enable !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0 || mem_addr !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_wait: en=%b ifv=%b dv=%b addr=%h, required 0 0 0 0000",
                     mem_enable, if_valid, d_valid, mem_addr);
        end
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (if_valid || d_valid || mem_enable) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abandoned_pulse: saw %0d active cycles after reset, required 0", pulses);
        end
    endtask

    task automatic test_single(input bit is_d, input bit wr, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] exp, input string name);
        int n;
        bit held;
        if (is_d) begin
            d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
            d_q.push_back(exp);
        end else begin
            if_req = 1'b1; if_addr = addr;
            if_q.push_back(exp);
        end
        @(negedge clk);
        checks++;
        if (mem_enable !== 1'b1 || mem_wr !== wr || mem_addr !== addr || (wr && mem_data_in !== wdata)) begin
            errors++;
            $display("FAIL %s_issue: en=%b wr=%b addr=%h din=%h, required 1 %b %h %h",
                     name, mem_enable, mem_wr, mem_addr, mem_data_in, wr, addr, wdata);
        end
        if (is_d) d_addr = ~addr;
        else if_addr = ~addr;
        n = 0;
        held = 1'b1;
        while (!(is_d ? d_valid : if_valid) && n < 40) begin
            @(negedge clk);
            n++;
            if (mem_addr !== addr || mem_enable !== 1'b0) held = 1'b0;
        end
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL %s_latency: valid %0d cycles after enable, required %0d", name, n, LAT);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL %s_addr_hold: mem_addr/mem_enable changed during access, required %h / 0", name, addr);
        end
        checks++;
        if ((is_d ? d_stall : if_stall) !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall: stall=1 during valid, required 0", name);
        end
        if (is_d) d_req = 1'b0;
        else if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ((is_d ? d_valid : if_valid) !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: valid still 1 next cycle, required 0", name);
        end
    endtask

    task automatic test_priority();
        int n, m;
        bit stall_ok;
        do_reset();
        if_req = 1'b1; if_addr = 16'h0010;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
        if_q.push_back(16'hA123);
        d_q.push_back(16'h0300 ^ 16'h5A5A);
        @(negedge clk);
        checks++;
        if (mem_enable !== 1'b1 || mem_addr !== 16'h0300) begin
            errors++;
            $display("FAIL prio_first_grant: en=%b addr=%h, required 1 0300", mem_enable, mem_addr);
        end
        n = 0;
        stall_ok = 1'b1;
        while (!d_valid && n < 40) begin
            if (if_stall !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != LAT || !stall_ok || if_stall !== 1'b1) begin
            errors++;
            $display("FAIL prio_data_done: latency %0d stall_ok=%b if_stall=%b, required %0d 1 1",
                     n, stall_ok, if_stall, LAT);
        end
        d_req = 1'b0;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!mem_enable && m < 20);
        checks++;
        if (m != 2 || mem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL prio_fetch_grant: enable %0d cycles after d_valid addr=%h, required 2 0010", m, mem_addr);
        end
        n = 0;
        while (!if_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != LAT) begin
            errors++;
            $display("FAIL prio_fetch_latency: %0d, required %0d", n, LAT);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alternate();
        bit last_d, exp_d;
        int t, prev;
        do_reset();
        if_req = 1'b1; if_addr = 16'h0100;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
        if_q.push_back(16'h0100 ^ 16'h5A5A);
        d_q.push_back(16'h0400 ^ 16'h5A5A);
        last_d = 1'b0;
        t = 0;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            int w;
            w = 0;
            while (!(if_valid || d_valid) && w < 40) begin
                @(negedge clk);
                w++;
                t++;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = ~last_d;
`else
            exp_d = 1'b1;
`endif
            checks++;
            if (w >= 40 || d_valid !== exp_d) begin
                errors++;
                $display("FAIL grant_order_%0d: d_valid=%b if_valid=%b, required d_valid=%b", i, d_valid, if_valid, exp_d);
            end
            if (i > 0) begin
                checks++;
                if (t - prev != LAT + 2) begin
                    errors++;
                    $display("FAIL grant_spacing_%0d: %0d cycles, required %0d", i, t - prev, LAT + 2);
                end
            end
            prev = t;
            last_d = d_valid;
            if (d_valid) begin
                d_addr = d_addr + 16'd1;
                d_q.push_back(d_addr ^ 16'h5A5A);
            end else begin
                if_addr = if_addr + 16'd1;
                if_q.push_back(if_addr ^ 16'h5A5A);
            end
            @(negedge clk);
            t++;
        end
        if_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_enable !== 1'b0) begin
            errors++;
            $display("FAIL alt_no_grant: mem_enable=%b after requests dropped, required 0", mem_enable);
        end
        if_q.delete();
        d_q.delete();
    endtask

    task automatic test_lat1();
        int m;
        if_req1 = 1'b1; if_addr1 = 16'h0000;
        @(negedge clk);
        checks++;
        if (mem_enable1 !== 1'b1 || mem_addr1 !== 16'h0000) begin
            errors++;
            $display("FAIL lat1_issue: en=%b addr=%h, required 1 0000", mem_enable1, mem_addr1);
        end
        @(negedge clk);
        checks++;
        if (if_valid1 !== 1'b1 || if_rdata1 !== 16'h5A5A) begin
            errors++;
            $display("FAIL lat1_first: valid=%b rdata=%h, required 1 5a5a", if_valid1, if_rdata1);
        end
        if_addr1 = 16'h0001;
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!mem_enable1 && m < 20);
        checks++;
        if (m != 2 || mem_addr1 !== 16'h0001) begin
            errors++;
            $display("FAIL lat1_second_issue: enable %0d cycles after valid addr=%h, required 2 0001", m, mem_addr1);
        end
        @(negedge clk);
        checks++;
        if (if_valid1 !== 1'b1 || if_rdata1 !== 16'h5A5B) begin
            errors++;
            $display("FAIL lat1_second: valid=%b rdata=%h, required 1 5a5b", if_valid1, if_rdata1);
        end
        if_req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL lat1_pulse: valid=%b, required 0", if_valid1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_req = 1'b0; if_addr = 16'd0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = 16'd0; d_wdata = 16'd0;
        if_req1 = 1'b0; if_addr1 = 16'd0;
        d_req1 = 1'b0; d_wr1 = 1'b0; d_addr1 = 16'd0; d_wdata1 = 16'd0;

        test_reset();
        test_reset_mid_wait();
        test_single(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA123, "fetch");
        test_single(1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'h0000, "store");
        test_single(1'b1, 1'b0, 16'h0200, 16'h0000, 16'hBEEF, "load_back");
        test_priority();
        test_alternate();
        test_lat1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
